mult_div_unit: RTL and testbench

- Multi-cycle multiply/divide unit in the EX stage, beside the ALU.
- Consumes the same forwarded operands `SrcA_E`/`SrcB_E` and owns the architectural HI/LO registers.
- Its `HI`/`LO` outputs are selected alongside `AO_E` into the EX/MEM register for MFHI/MFLO.
- `Busy` feeds the hazard unit, which stalls dependent MDU instructions while an operation is in flight.

---
 rtl/mult_div_unit_if.sv | 21 ++
 rtl/mult_div_unit.sv | 157 +++++++++++++++
 tb/tb_mult_div_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Operand, control and result bundle between the EX stage and the multiply/divide unit.
interface mult_div_unit_if;
    logic [31:0] SrcA_E;
    logic [31:0] SrcB_E;
    logic [3:0]  MDOp_E;
    logic        MDRead_E;
    logic        Busy;
    logic        Stall_E;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output SrcA_E, SrcB_E, MDOp_E, MDRead_E,
        input  Busy, Stall_E, HI, LO
    );

    modport slave (
        input  SrcA_E, SrcB_E, MDOp_E, MDRead_E,
        output Busy, Stall_E, HI, LO
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning architectural HI/LO; result is computed at start
// and committed after a fixed busy period. Define MDU_MADD_EN to enable MADD/MADDU.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic             clk,
    input logic             reset,
    mult_div_unit_if.slave  mdu
);

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [3:0] {
        OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
        OP_MTHI, OP_MTLO, OP_MADD, OP_MADDU
    } op_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] phi_q, phi_d;
    logic [31:0] plo_q, plo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    op_t         op;
    logic        start;
    logic [31:0] n_cycles;
    logic [63:0] res;
    logic        busy;

    function automatic logic [63:0] mul_s(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] xa;
        logic signed [63:0] xb;
        xa = {{32{a[31]}}, a};
        xb = {{32{b[31]}}, b};
        return xa * xb;
    endfunction

    function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa;
        logic [63:0] xb;
        xa = {32'd0, a};
        xb = {32'd0, b};
        return xa * xb;
    endfunction

    // Results are packed {remainder, quotient} so they land directly in {HI, LO}.
    function automatic logic [63:0] div_s(input logic signed [31:0] a, input logic signed [31:0] b);
        logic signed [31:0] q;
        logic signed [31:0] r;
        if (b == 32'sd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'sh8000_0000 && b == -32'sd1) return {32'd0, 32'h8000_0000};
        q = a / b;
        r = a % b;
        return {r, q};
    endfunction

    function automatic logic [63:0] div_u(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
    endfunction

    always_comb begin
        case (mdu.MDOp_E)
            4'd1:    op = OP_MULT;
            4'd2:    op = OP_MULTU;
            4'd3:    op = OP_DIV;
            4'd4:    op = OP_DIVU;
            4'd5:    op = OP_MTHI;
            4'd6:    op = OP_MTLO;
`ifdef MDU_MADD_EN
            4'd7:    op = OP_MADD;
            4'd8:    op = OP_MADDU;
`endif
            default: op = OP_NONE;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        phi_d    = phi_q;
        plo_d    = plo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        start    = 1'b0;
        n_cycles = 32'(MULT_CYCLES);
        res      = 64'd0;
        case (state_q)
            IDLE: begin
                case (op)
                    OP_MULT:  begin res = mul_s(mdu.SrcA_E, mdu.SrcB_E); start = 1'b1; end
                    OP_MULTU: begin res = mul_u(mdu.SrcA_E, mdu.SrcB_E); start = 1'b1; end
                    OP_DIV: begin
                        res = div_s(mdu.SrcA_E, mdu.SrcB_E);
                        start = 1'b1;
                        n_cycles = 32'(DIV_CYCLES);
                    end
                    OP_DIVU: begin
                        res = div_u(mdu.SrcA_E, mdu.SrcB_E);
                        start = 1'b1;
                        n_cycles = 32'(DIV_CYCLES);
                    end
                    OP_MTHI:  hi_d = mdu.SrcA_E;
                    OP_MTLO:  lo_d = mdu.SrcA_E;
`ifdef MDU_MADD_EN
                    // Accumulates onto the HI/LO held at the start edge, wrapping at 64 bits.
                    OP_MADD:  begin res = {hi_q, lo_q} + mul_s(mdu.SrcA_E, mdu.SrcB_E); start = 1'b1; end
                    OP_MADDU: begin res = {hi_q, lo_q} + mul_u(mdu.SrcA_E, mdu.SrcB_E); start = 1'b1; end
`endif
                    default: ;
                endcase
                if (start) begin
                    {phi_d, plo_d} = res;
                    cnt_d          = n_cycles;
                    state_d        = RUN;
                end
            end
            RUN: begin
                if (cnt_q == 32'd1) begin
                    hi_d    = phi_q;
                    lo_d    = plo_q;
                    cnt_d   = 32'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 32'd0;
            phi_q   <= 32'd0;
            plo_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign mdu.Busy    = busy;
    assign mdu.HI      = hi_q;
    assign mdu.LO      = lo_q;
    assign mdu.Stall_E = busy & ((op != OP_NONE) | mdu.MDRead_E);

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: table of arithmetic results plus hand-written
// sequences for stalls, ignored ops, reset interactions and the MADD option.
module tb_mult_div_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[12];

    always #5 clk = ~clk;

    mult_div_unit_if bus ();

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge: drives the op for cycle T0, then checks Busy over T0+1..T0+lat+1
    // and the committed HI/LO in the cycle Busy falls. Returns at that cycle's negedge.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int lat);
        bus.MDOp_E = op;
        bus.SrcA_E = a;
        bus.SrcB_E = b;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            bus.MDOp_E = 4'd0;
            chk({name, "_busy"}, 32'(bus.Busy), 32'(k <= lat));
        end
        chk({name, "_hi"}, bus.HI, ehi);
        chk({name, "_lo"}, bus.LO, elo);
    endtask

    initial begin
        vecs[0]  = '{"mult_neg2x3",   4'd1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, MC};
        vecs[1]  = '{"multu_neg2x3",  4'd2, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA, MC};
        vecs[2]  = '{"div_m7_2",      4'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
        vecs[3]  = '{"divu_7_0",      4'd4, 32'd7,         32'd0,        32'h0000_0007, 32'hFFFF_FFFF, DC};
        vecs[4]  = '{"div_ovf",       4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DC};
        vecs[5]  = '{"div_7_0",       4'd3, 32'd7,         32'd0,        32'h0000_0007, 32'hFFFF_FFFF, DC};
        vecs[6]  = '{"divu_big_2",    4'd4, 32'hFFFF_FFF9, 32'd2,        32'h0000_0001, 32'h7FFF_FFFC, DC};
        vecs[7]  = '{"mult_min_min",  4'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MC};
        vecs[8]  = '{"multu_max_max", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MC};
        vecs[9]  = '{"div_7_m2",      4'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DC};
        vecs[10] = '{"mult_x_0",      4'd1, 32'h1234_5678, 32'd0,        32'h0000_0000, 32'h0000_0000, MC};
        vecs[11] = '{"divu_100_7",    4'd4, 32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E, DC};

        reset        = 1'b1;
        bus.SrcA_E   = 32'd0;
        bus.SrcB_E   = 32'd0;
        bus.MDOp_E   = 4'd0;
        bus.MDRead_E = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_hi", bus.HI, 32'd0);
        chk("rst_lo", bus.LO, 32'd0);
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_stall", 32'(bus.Stall_E), 32'd0);

        // Consecutive vectors start in the very cycle the previous Busy falls.
        for (int i = 0; i < 12; i++)
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].lat);

        // MT and MF requests while a divide is in flight.
        bus.MDOp_E = 4'd3; bus.SrcA_E = 32'd100; bus.SrcB_E = 32'd7;
        for (int k = 1; k <= DC + 1; k++) begin
            @(negedge clk);
            bus.MDOp_E = 4'd0;
            if (k == 2) begin
                bus.MDOp_E = 4'd5; bus.SrcA_E = 32'h1234;
                #1 chk("stall_mthi", 32'(bus.Stall_E), 32'd1);
            end
            if (k == 3) begin
                bus.MDRead_E = 1'b1;
                #1 chk("stall_mfhi", 32'(bus.Stall_E), 32'd1);
            end
            if (k == 4) begin
                bus.MDRead_E = 1'b0;
                #1 chk("stall_none", 32'(bus.Stall_E), 32'd0);
            end
        end
        chk("ign_busy", 32'(bus.Busy), 32'd0);
        chk("ign_hi", bus.HI, 32'd2);
        chk("ign_lo", bus.LO, 32'h0000_000E);
        bus.MDOp_E = 4'd5; bus.SrcA_E = 32'h1234;
        @(negedge clk);
        chk("mthi_hi", bus.HI, 32'h1234);
        chk("mthi_busy", 32'(bus.Busy), 32'd0);
        bus.MDOp_E = 4'd6; bus.SrcA_E = 32'h5678;
        @(negedge clk);
        bus.MDOp_E = 4'd0;
        chk("mtlo_lo", bus.LO, 32'h5678);
        chk("mtlo_hi", bus.HI, 32'h1234);
        bus.MDRead_E = 1'b1;
        #1 chk("mf_idle_stall", 32'(bus.Stall_E), 32'd0);
        bus.MDRead_E = 1'b0;

        // Reset in cycle T0+3 of a divide abandons it for good.
        bus.MDOp_E = 4'd3; bus.SrcA_E = 32'hFFFF_FFF9; bus.SrcB_E = 32'd2;
        repeat (3) begin
            @(negedge clk);
            bus.MDOp_E = 4'd0;
        end
        chk("mid_busy_before", 32'(bus.Busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_busy", 32'(bus.Busy), 32'd0);
        chk("mid_hi", bus.HI, 32'd0);
        chk("mid_lo", bus.LO, 32'd0);
        repeat (DC + 2) @(negedge clk);
        chk("mid_late_hi", bus.HI, 32'd0);
        chk("mid_late_lo", bus.LO, 32'd0);
        chk("mid_late_busy", 32'(bus.Busy), 32'd0);

        // Reset and start on the same edge.
        reset = 1'b1; bus.MDOp_E = 4'd1; bus.SrcA_E = 32'd3; bus.SrcB_E = 32'd4;
        @(negedge clk);
        reset = 1'b0; bus.MDOp_E = 4'd0;
        chk("rst_start_busy", 32'(bus.Busy), 32'd0);
        repeat (MC + 2) @(negedge clk);
        chk("rst_start_lo", bus.LO, 32'd0);

        bus.MDOp_E = 4'd5; bus.SrcA_E = 32'd0;
        @(negedge clk);
        bus.MDOp_E = 4'd6; bus.SrcA_E = 32'hFFFF_FFFF;
        @(negedge clk);
`ifdef MDU_MADD_EN
        run_op("maddu_1x1", 4'd8, 32'd1, 32'd1, 32'd1, 32'd0, MC);
        run_op("madd_m1x1", 4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, MC);
`else
        bus.MDOp_E = 4'd7; bus.SrcA_E = 32'd1; bus.SrcB_E = 32'd1;
        #1 chk("c7_stall", 32'(bus.Stall_E), 32'd0);
        @(negedge clk);
        bus.MDOp_E = 4'd0;
        chk("c7_busy", 32'(bus.Busy), 32'd0);
        repeat (MC + 1) @(negedge clk);
        chk("c7_hi", bus.HI, 32'd0);
        chk("c7_lo", bus.LO, 32'hFFFF_FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
